// File: rtl/shift_unit_pipe_pkg.sv
// Shared types for the pipelined shift unit: operation encoding and the
// level-to-stage split used by the top-level generate loop.
package shift_unit_pipe_pkg;

    typedef enum logic [2:0] {
        SH_SLL = 3'd0,
        SH_SRL = 3'd1,
        SH_SRA = 3'd2,
        SH_ROL = 3'd3,
        SH_ROR = 3'd4
    } shift_op_t;

    // Lowest level k whose floor(k*stages/levels) equals s.
    function automatic int first_level(input int s, input int levels, input int stages);
        return (s * levels + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/shift_unit_pipe_level.sv
// One combinational barrel-shifter level: shifts or rotates by DIST when enabled.
// Unknown op encodings fall through to the arithmetic-right path.
module shift_level
    import shift_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             enable,
    input  shift_op_t        op,
    input  logic             sign,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = data;
        if (enable) begin
            case (op)
                SH_SLL:  result = data << DIST;
                SH_SRL:  result = data >> DIST;
                SH_ROL:  result = (data << DIST) | (data >> (WIDTH - DIST));
                SH_ROR:  result = (data >> DIST) | (data << (WIDTH - DIST));
                default: result = (data >> DIST) | ({WIDTH{sign}} << (WIDTH - DIST));
            endcase
        end
    end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter with valid/ready backpressure, flush and a sideband tag.
// The log2(WIDTH) shift levels are spread over STAGES register stages.
module shift_unit_pipe
    import shift_unit_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  shift_op_t                in_op,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int LEVELS = $clog2(WIDTH);

    logic stall;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int FIRST = first_level(s, LEVELS, STAGES);
        localparam int NEXT  = first_level(s + 1, LEVELS, STAGES);

        logic [WIDTH-1:0]      src_data;
        shift_op_t             src_op;
        logic                  src_sign;
        logic                  src_valid;
        logic [LEVELS-1:FIRST] src_amt;
        logic [TAG_W-1:0]      src_tag;
        logic [WIDTH-1:0]      chain [FIRST:NEXT];
        logic [WIDTH-1:0]      data_q;
        logic [TAG_W-1:0]      tag_q;
        logic                  valid_q;

        if (s == 0) begin : g_src_in
            assign src_data  = in_a;
            assign src_op    = in_op;
            assign src_sign  = in_a[WIDTH-1];
            assign src_amt   = in_amt;
            assign src_tag   = in_tag;
            assign src_valid = in_valid & in_ready;
        end else begin : g_src_prev
            assign src_data  = g_stage[s-1].data_q;
            assign src_op    = g_stage[s-1].g_fwd.op_q;
            assign src_sign  = g_stage[s-1].g_fwd.sign_q;
            assign src_amt   = g_stage[s-1].g_fwd.amt_q;
            assign src_tag   = g_stage[s-1].tag_q;
            assign src_valid = g_stage[s-1].valid_q;
        end

        assign chain[FIRST] = src_data;

        for (genvar k = FIRST; k < NEXT; k++) begin : g_level
            shift_level #(
                .WIDTH (WIDTH),
                .DIST  (1 << k)
            ) u_level (
                .data   (chain[k]),
                .enable (src_amt[k]),
                .op     (src_op),
                .sign   (src_sign),
                .result (chain[k+1])
            );
        end

        // Flush clears occupancy even while stalled; data simply holds.
        always_ff @(posedge clk) begin
            if (reset || flush) begin
                valid_q <= 1'b0;
            end else if (!stall) begin
                valid_q <= src_valid;
            end
        end

        if (s == STAGES - 1) begin : g_out
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_q <= '0;
                    tag_q  <= '0;
                end else if (!stall) begin
                    data_q <= chain[NEXT];
                    tag_q  <= src_tag;
                end
            end
        end else begin : g_fwd
            // Only the amount bits for levels still ahead are carried forward.
            shift_op_t            op_q;
            logic                 sign_q;
            logic [LEVELS-1:NEXT] amt_q;

            always_ff @(posedge clk) begin
                if (!stall) begin
                    data_q <= chain[NEXT];
                    tag_q  <= src_tag;
                    op_q   <= src_op;
                    sign_q <= src_sign;
                    amt_q  <= src_amt[LEVELS-1:NEXT];
                end
            end
        end
    end

    assign out_valid  = g_stage[STAGES-1].valid_q;
    assign out_result = g_stage[STAGES-1].data_q;
    assign out_tag    = g_stage[STAGES-1].tag_q;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed bench for shift_unit_pipe (WIDTH=32, STAGES=3) with a result/tag scoreboard.
module tb_shift_unit_pipe;
    import shift_unit_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    shift_op_t   in_op;
    logic [31:0] in_a, out_result;
    logic [4:0]  in_amt, in_tag, out_tag;

    always #5 clk = ~clk;

    shift_unit_pipe #(.WIDTH(32), .STAGES(3), .TAG_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_amt     (in_amt),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    int          tests = 0;
    int          fails = 0;
    int          pops  = 0;
    logic [31:0] exp_res_q[$];
    logic [4:0]  exp_tag_q[$];
    logic [31:0] next_exp;
    logic        accepted;
    logic        hold_chk;
    logic [31:0] held_res;
    logic [4:0]  held_tag;

    function automatic logic [31:0] ref_shift(input shift_op_t op, input logic [31:0] a,
                                              input logic [4:0] amt);
        logic [63:0] t;
        case (op)
            SH_SLL:  return a << amt;
            SH_SRL:  return a >> amt;
            SH_ROL:  begin t = {a, a} << amt; return t[63:32]; end
            SH_ROR:  begin t = {a, a} >> amt; return t[31:0]; end
            default: return $unsigned($signed(a) >>> amt);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already set; advances one clock.
    task automatic tick();
        #1;
        check("in_ready_fn", in_ready, !(out_valid && !out_ready));
        accepted = 1'b0;
        if (reset) begin
            exp_res_q.delete();
            exp_tag_q.delete();
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_result", out_result, held_res);
                check("hold_tag", out_tag, held_tag);
            end
            if (out_valid && out_ready) begin
                if (exp_res_q.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 1'b0);
                end else begin
                    check("result", out_result, exp_res_q.pop_front());
                    check("tag", out_tag, exp_tag_q.pop_front());
                    pops++;
                end
            end
            hold_chk = out_valid && !out_ready && !flush;
            held_res = out_result;
            held_tag = out_tag;
            if (flush) begin
                exp_res_q.delete();
                exp_tag_q.delete();
            end else if (in_valid && in_ready) begin
                accepted = 1'b1;
                exp_res_q.push_back(next_exp);
                exp_tag_q.push_back(in_tag);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input shift_op_t op, input logic [31:0] a, input logic [4:0] amt,
                         input logic [4:0] tag, input logic [31:0] exp);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_amt   = amt;
        in_tag   = tag;
        next_exp = exp;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 30 && exp_res_q.size() != 0; n++) tick();
        check("drain_empty", exp_res_q.size(), 0);
    endtask

    task automatic single(input shift_op_t op, input logic [31:0] a, input logic [4:0] amt,
                          input logic [4:0] tag, input logic [31:0] exp);
        drive(op, a, amt, tag, exp);
        tick();
        check("accepted", accepted, 1'b1);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] sa   [10];
        logic [4:0]  samt [10];
        shift_op_t   op;
        int          idx, lat, pops0;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = SH_SLL; in_a = '0; in_amt = '0; in_tag = '0;
        next_exp = '0; hold_chk = 1'b0; accepted = 1'b0;
        held_res = '0; held_tag = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_tag", out_tag, 5'd0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);

        // SLL by 31 with latency measurement
        drive(SH_SLL, 32'h0000_0001, 5'd31, 5'd7, 32'h8000_0000);
        tick();
        check("sll_accepted", accepted, 1'b1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("sll_latency", lat, 3);
        drain();

        single(SH_SRA, 32'h8000_0000, 5'd4, 5'd1, 32'hF800_0000);
        single(SH_SRL, 32'h8000_0000, 5'd4, 5'd2, 32'h0800_0000);
        single(SH_SRA, 32'h7FFF_FFFF, 5'd31, 5'd3, 32'h0000_0000);
        single(shift_op_t'(3'd7), 32'h8000_0000, 5'd4, 5'd4, 32'hF800_0000);
        single(SH_ROL, 32'h8000_0001, 5'd1, 5'd5, 32'h0000_0003);
        single(SH_ROR, 32'h0000_0001, 5'd4, 5'd6, 32'h1000_0000);
        for (int i = 0; i < 5; i++) begin
            single(shift_op_t'(3'(i)), 32'hDEAD_BEEF, 5'd0, 5'(20 + i), 32'hDEAD_BEEF);
        end

        // Back-to-back stream with consumer stall in cycles 5..7
        for (int i = 0; i < 10; i++) begin
            sa[i]   = $urandom;
            samt[i] = 5'($urandom_range(0, 31));
        end
        pops0 = pops;
        idx   = 0;
        for (int cyc = 0; cyc < 60 && idx < 10; cyc++) begin
            op = shift_op_t'(3'(idx % 5));
            drive(op, sa[idx], samt[idx], 5'(idx + 10), ref_shift(op, sa[idx], samt[idx]));
            out_ready = !(cyc >= 5 && cyc <= 7);
            if (cyc >= 5 && cyc <= 7) begin
                #1;
                check("stall_in_ready", in_ready, 1'b0);
            end
            tick();
            if (accepted) idx++;
        end
        out_ready = 1'b1;
        drain();
        check("stream_count", pops - pops0, 10);

        // Flush with three operations in flight
        drive(SH_SLL, 32'h0000_00F0, 5'd4, 5'd11, 32'h0000_0F00);
        tick();
        drive(SH_SRL, 32'h0000_00F0, 5'd4, 5'd12, 32'h0000_000F);
        tick();
        drive(SH_ROL, 32'hF000_0000, 5'd4, 5'd13, 32'h0000_000F);
        tick();
        flush = 1'b1;
        drive(SH_ROR, 32'h0000_000F, 5'd4, 5'd14, 32'hF000_0000);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("flush_out_valid", out_valid, 1'b0);
            tick();
        end
        single(SH_SRA, 32'hC000_0000, 5'd2, 5'd15, 32'hF000_0000);

        // Reset with the pipe full and stalled
        out_ready = 1'b0;
        drive(SH_SLL, 32'h1234_5678, 5'd0, 5'd16, 32'h1234_5678);
        tick();
        drive(SH_SLL, 32'h0000_0003, 5'd1, 5'd17, 32'h0000_0006);
        tick();
        drive(SH_SRL, 32'hFFFF_0000, 5'd8, 5'd18, 32'h00FF_FF00);
        tick();
        in_valid = 1'b0;
        tick();
        check("full_out_valid", out_valid, 1'b1);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_result", out_result, 32'h0);
        check("midrst_out_tag", out_tag, 5'd0);
        check("midrst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        single(SH_ROR, 32'h8000_0001, 5'd1, 5'd19, 32'hC000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
